// File: rtl/mac_stat_pkg.sv
// mac_stat_pkg: shared constants, defaults and FSM encoding for the MAC statistics block
package mac_stat_pkg;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 11;
    localparam int NUM_CNT       = 6;

    localparam logic [7:0] STAT_RX_FRAMES = 8'h00;
    localparam logic [7:0] STAT_RX_BYTES  = 8'h01;
    localparam logic [7:0] STAT_TX_FRAMES = 8'h02;
    localparam logic [7:0] STAT_TX_BYTES  = 8'h03;
    localparam logic [7:0] STAT_CRC_ERRS  = 8'h04;
    localparam logic [7:0] STAT_DROPS     = 8'h05;
    localparam logic [7:0] STAT_CLR_ALL   = 8'hFF;

    typedef enum logic {ST_IDLE, ST_SEND} stat_state_e;

endpackage

// File: rtl/stat_counter.sv
// stat_counter: one statistics counter with clear priority; MAC_STAT_SATURATE_EN selects saturate instead of wrap
module stat_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int LEN_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic [LEN_WIDTH-1:0] inc_val,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef MAC_STAT_SATURATE_EN
    logic [CNT_WIDTH:0] sum;

    // Next value: clear beats increment; the carry out of the add clamps to all-ones
    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_val);
        cnt_d = clr ? '0 : !inc_en ? cnt_q : sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end
`else
    // Next value: clear beats increment; the add wraps modulo 2^CNT_WIDTH
    always_comb begin
        cnt_d = clr ? '0 : inc_en ? cnt_q + CNT_WIDTH'(inc_val) : cnt_q;
    end
`endif

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mac_stat_mgnt.sv
// mac_stat_mgnt: per-port MAC statistics with byte-serial MSB-first readout and clear; MAC_STAT_SATURATE_EN makes counters saturate
module mac_stat_mgnt
    import mac_stat_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_wr,
    input  logic [7:0]           req_addr,
    output logic                 resp_valid,
    output logic [7:0]           resp_data,
    input  logic                 rx_frame_valid,
    input  logic [LEN_WIDTH-1:0] rx_frame_len,
    input  logic                 rx_crc_err,
    input  logic                 rx_drop,
    input  logic                 tx_frame_valid,
    input  logic [LEN_WIDTH-1:0] tx_frame_len
);

    localparam int NB = CNT_WIDTH / 8;
    localparam int BW = $clog2(NB + 1);

    logic [NUM_CNT-1:0]   inc_en, clr;
    logic [LEN_WIDTH-1:0] inc_val [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
    logic [CNT_WIDTH-1:0] sel;

    stat_state_e          state_q;
    logic [CNT_WIDTH-1:0] shift_q;
    logic [BW-1:0]        byte_cnt_q;
    logic                 resp_valid_q;
    logic [7:0]           resp_data_q;

    // Route MAC events and clears to counters indexed by their address; read mux sees pre-increment values
    always_comb begin
        inc_en = {rx_drop, rx_crc_err, tx_frame_valid, tx_frame_valid, rx_frame_valid, rx_frame_valid};
        for (int k = 0; k < NUM_CNT; k++) inc_val[k] = LEN_WIDTH'(1);
        inc_val[STAT_RX_BYTES[2:0]] = rx_frame_len;
        inc_val[STAT_TX_BYTES[2:0]] = tx_frame_len;
        sel = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            clr[k] = req_valid && req_wr && (req_addr == 8'(k) || req_addr == STAT_CLR_ALL);
            if (req_addr == 8'(k)) sel = cnt[k];
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        stat_counter #(.CNT_WIDTH(CNT_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_en (inc_en[i]),
            .inc_val(inc_val[i]),
            .clr    (clr[i]),
            .cnt    (cnt[i])
        );
    end

    // Readout FSM: the first byte leaves with the snapshot, the rest shift out back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid && !req_wr) begin
                    state_q      <= ST_SEND;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= sel[CNT_WIDTH-1 -: 8];
                    shift_q      <= sel << 8;
                    byte_cnt_q   <= BW'(1);
                end
                ST_SEND: if (byte_cnt_q == BW'(NB)) begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    byte_cnt_q   <= '0;
                end else begin
                    resp_data_q  <= shift_q[CNT_WIDTH-1 -: 8];
                    shift_q      <= shift_q << 8;
                    byte_cnt_q   <= byte_cnt_q + BW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mac_stat_mgnt.sv
// tb_mac_stat_mgnt: directed scoreboard bench for mac_stat_mgnt
module tb_mac_stat_mgnt;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr;
    logic [7:0]  req_addr;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        rx_frame_valid, rx_crc_err, rx_drop, tx_frame_valid;
    logic [10:0] rx_frame_len, tx_frame_len;

    logic [7:0]  q [$];
    int          nasrt = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    mac_stat_mgnt dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .rx_frame_valid(rx_frame_valid),
        .rx_frame_len  (rx_frame_len),
        .rx_crc_err    (rx_crc_err),
        .rx_drop       (rx_drop),
        .tx_frame_valid(tx_frame_valid),
        .tx_frame_len  (tx_frame_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push32(input logic [31:0] v);
        for (int b = 3; b >= 0; b--) q.push_back(v[8*b +: 8]);
    endtask

    task automatic zero_in();
        req_valid = 0; req_wr = 0; req_addr = 0;
        rx_frame_valid = 0; rx_frame_len = 0; rx_crc_err = 0; rx_drop = 0;
        tx_frame_valid = 0; tx_frame_len = 0;
    endtask

    task automatic cyc(input logic rxv, input logic [10:0] rxl, input logic crc, input logic drp,
                       input logic txv, input logic [10:0] txl,
                       input logic rv, input logic wr, input logic [7:0] addr);
        @(negedge clk);
        rx_frame_valid = rxv; rx_frame_len = rxl; rx_crc_err = crc; rx_drop = drp;
        tx_frame_valid = txv; tx_frame_len = txl;
        req_valid = rv; req_wr = wr; req_addr = addr;
        @(negedge clk);
        zero_in();
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input logic rxv);
        push32(exp);
        cyc(rxv, 11'd64, 0, 0, 0, 0, 1, 0, addr);
        for (int k = 0; k < 4; k++) begin
            chk("rd_valid", 32'(resp_valid), 1);
            @(negedge clk);
        end
        chk("rd_done", 32'(resp_valid), 0);
        chk("rd_drain", 32'(q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            chk("unexpected_byte", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("resp_byte", 32'(resp_data), 32'(q.pop_front()));
        end else begin
            chk("idle_data", 32'(resp_data), 0);
        end
    end

    initial begin
        rst = 1;
        zero_in();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_data", 32'(resp_data), 0);
        rst = 0;

        cyc(1, 11'd64, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 11'd1518, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 11'd60, 0, 0, 0, 0, 0, 0, 0);
        do_read(8'h00, 3, 0);
        do_read(8'h01, 64 + 1518 + 60, 0);

        @(negedge clk);
        force dut.g_cnt[3].u_cnt.cnt_q = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.g_cnt[3].u_cnt.cnt_q;
        cyc(0, 0, 0, 0, 1, 11'd64, 0, 0, 0);
`ifdef MAC_STAT_SATURATE_EN
        do_read(8'h03, 32'hFFFF_FFFF, 0);
`else
        do_read(8'h03, 32'h0000_0030, 0);
`endif
        do_read(8'h02, 1, 0);

        cyc(0, 0, 1, 0, 0, 0, 1, 1, 8'h04);
        do_read(8'h04, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        do_read(8'h04, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 1, 8'h20);
        do_read(8'h05, 1, 0);
        do_read(8'h00, 3, 0);

        cyc(1, 11'd64, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 11'd64, 0, 0, 0, 0, 0, 0, 0);
        do_read(8'h00, 5, 1);
        do_read(8'h00, 6, 0);

        push32(6);
        @(negedge clk);
        req_valid = 1; req_addr = 8'h00;
        @(negedge clk);
        req_valid = 0;
        chk("busy_b0", 32'(resp_valid), 1);
        @(negedge clk);
        chk("busy_b1", 32'(resp_valid), 1);
        req_valid = 1; req_addr = 8'h01;
        @(negedge clk);
        req_valid = 0;
        chk("busy_b2", 32'(resp_valid), 1);
        @(negedge clk);
        chk("busy_b3", 32'(resp_valid), 1);
        @(negedge clk);
        chk("busy_end", 32'(resp_valid), 0);
        repeat (5) @(negedge clk);
        chk("busy_drain", 32'(q.size()), 0);

        cyc(0, 0, 0, 0, 0, 0, 1, 1, 8'hFF);
        for (int a = 0; a < 6; a++) do_read(8'(a), 0, 0);

        repeat (7) cyc(1, 11'd100, 0, 0, 0, 0, 0, 0, 0);
        push32(7);
        @(negedge clk);
        req_valid = 1; req_addr = 8'h00;
        @(negedge clk);
        req_valid = 0;
        chk("abort_b0", 32'(resp_valid), 1);
        @(posedge clk);
        #1 rst = 1;
        q.delete();
        @(negedge clk);
        chk("abort_c", 32'(resp_valid), 0);
        @(negedge clk);
        chk("abort_d", 32'(resp_valid), 0);
        rst = 0;
        @(negedge clk);
        chk("abort_e", 32'(resp_valid), 0);
        do_read(8'h00, 0, 0);
        do_read(8'h20, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
